// File: rtl/ff_bank_rd_pkg.sv
// Shared types and constants for the ff_bank_rd frame reader.
// Holds the FSM state encoding, default geometry and the index-width helper.
package ff_bank_rd_pkg;

   localparam int DEF_DATA_WIDTH  = 10;
   localparam int DEF_NUM_ENTRIES = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

   // Index width, never below one bit so a 2-entry frame still has an index.
   function automatic int idx_width(input int num_entries);
      return (num_entries <= 2) ? 1 : $clog2(num_entries);
   endfunction

endpackage

// File: rtl/ff_bank_rd_if.sv
// Bundle of the frame-load and word-stream signals of ff_bank_rd.
// The master side loads frames and consumes words; the slave side is the reader.
interface ff_bank_rd_if
   import ff_bank_rd_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int NUM_ENTRIES = DEF_NUM_ENTRIES
);

   logic                                Load_SI;
   logic [NUM_ENTRIES*DATA_WIDTH-1:0]   D_DI;
   logic                                LoadRdy_SO;
   logic                                Ready_SI;
   logic                                Valid_SO;
   logic signed [DATA_WIDTH-1:0]        Q_DO;
   logic                                Last_SO;

   modport master (
      output Load_SI, D_DI, Ready_SI,
      input  LoadRdy_SO, Valid_SO, Q_DO, Last_SO
   );

   modport slave (
      input  Load_SI, D_DI, Ready_SI,
      output LoadRdy_SO, Valid_SO, Q_DO, Last_SO
   );

endinterface

// File: rtl/ff_bank_rd_store.sv
// Load-enabled register bank holding one frame of words.
// A synchronous clear wipes every entry and wins over a simultaneous load.
module ff_bank_rd_store
   import ff_bank_rd_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int NUM_ENTRIES = DEF_NUM_ENTRIES
) (
   input  logic                              i_clk,
   input  logic                              i_clear,
   input  logic                              i_load,
   input  logic [NUM_ENTRIES*DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0]             o_bank [NUM_ENTRIES]
);

   logic [DATA_WIDTH-1:0] r_bank [NUM_ENTRIES];

   // NOTE: the bank is a register array, not RAM, so clearing every entry on reset is legal and required here.
   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         for (int k = 0; k < NUM_ENTRIES; k++) r_bank[k] <= '0;
      end else if (i_load) begin
         for (int k = 0; k < NUM_ENTRIES; k++) r_bank[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign o_bank = r_bank;

endmodule

// File: rtl/ff_bank_rd.sv
// Frame reader: parallel-loads a frame of signed words, then streams them out one per accepted transfer.
// Optional frame counter port FrameCnt_DO is enabled by defining FF_BANK_RD_FRAME_CNT_EN.
module ff_bank_rd
   import ff_bank_rd_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int NUM_ENTRIES = DEF_NUM_ENTRIES
) (
   input  logic                              Clk_CI,
   input  logic                              Rst_RBI,
   input  logic                              Load_SI,
   input  logic [NUM_ENTRIES*DATA_WIDTH-1:0] D_DI,
   output logic                              LoadRdy_SO,
   input  logic                              Ready_SI,
   output logic                              Valid_SO,
   output logic signed [DATA_WIDTH-1:0]      Q_DO,
   output logic                              Last_SO
`ifdef FF_BANK_RD_FRAME_CNT_EN
   ,
   output logic [7:0]                        FrameCnt_DO
`endif
);

   localparam int                IDX_W    = idx_width(NUM_ENTRIES);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   state_e                r_state;
   state_e                w_state_nxt;
   logic [IDX_W-1:0]      r_idx;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic                  w_load;
   logic [DATA_WIDTH-1:0] w_bank [NUM_ENTRIES];

   ff_bank_rd_store #(
      .DATA_WIDTH  (DATA_WIDTH),
      .NUM_ENTRIES (NUM_ENTRIES)
   ) u_store (
      .i_clk   (Clk_CI),
      .i_clear (!Rst_RBI),
      .i_load  (w_load),
      .i_data  (D_DI),
      .o_bank  (w_bank)
   );

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      LoadRdy_SO  = 1'b0;
      Valid_SO    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            LoadRdy_SO = 1'b1;
            if (Load_SI) begin
               w_load      = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            Valid_SO = 1'b1;
            if (Ready_SI) begin
               if (r_idx == LAST_IDX) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   assign Last_SO = Valid_SO && (r_idx == LAST_IDX);
   assign Q_DO    = Valid_SO ? $signed(w_bank[r_idx]) : '0;

`ifdef FF_BANK_RD_FRAME_CNT_EN
   logic [7:0] r_frame_cnt;

   // Counts completed frames; the 8-bit register wraps 255 -> 0 naturally.
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         r_frame_cnt <= '0;
      end else if (Valid_SO && Ready_SI && Last_SO) begin
         r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   assign FrameCnt_DO = r_frame_cnt;
`endif

endmodule

// File: tb/tb_ff_bank_rd.sv
// Self-checking bench for ff_bank_rd: queue-based frame model plus a per-cycle monitor.
// Covers ordinary frames, back-pressure, ignored loads, mid-frame reset, back-to-back loads and random traffic.
module tb_ff_bank_rd;
   import ff_bank_rd_pkg::*;

   localparam int DW = DEF_DATA_WIDTH;
   localparam int NE = DEF_NUM_ENTRIES;

   logic Clk_CI = 1'b0;
   logic Rst_RBI;
`ifdef FF_BANK_RD_FRAME_CNT_EN
   logic [7:0] FrameCnt_DO;
`endif

   ff_bank_rd_if #(.DATA_WIDTH(DW), .NUM_ENTRIES(NE)) bus ();

   ff_bank_rd #(
      .DATA_WIDTH  (DW),
      .NUM_ENTRIES (NE)
   ) dut (
      .Clk_CI     (Clk_CI),
      .Rst_RBI    (Rst_RBI),
      .Load_SI    (bus.Load_SI),
      .D_DI       (bus.D_DI),
      .LoadRdy_SO (bus.LoadRdy_SO),
      .Ready_SI   (bus.Ready_SI),
      .Valid_SO   (bus.Valid_SO),
      .Q_DO       (bus.Q_DO),
      .Last_SO    (bus.Last_SO)
`ifdef FF_BANK_RD_FRAME_CNT_EN
      ,
      .FrameCnt_DO(FrameCnt_DO)
`endif
   );

   always #5 Clk_CI = ~Clk_CI;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the words still to be delivered in the current frame, oldest first.
   logic signed [DW-1:0] exp_q [$];
   bit                   m_known  = 1'b0;
   int                   m_frames = 0;

   always @(negedge Clk_CI) begin
      if (m_known) begin
         if (exp_q.size() == 0) begin
            check("idle_valid",   int'(bus.Valid_SO),   0);
            check("idle_last",    int'(bus.Last_SO),    0);
            check("idle_q",       int'(bus.Q_DO),       0);
            check("idle_loadrdy", int'(bus.LoadRdy_SO), 1);
         end else begin
            check("valid",   int'(bus.Valid_SO),   1);
            check("loadrdy", int'(bus.LoadRdy_SO), 0);
            check("q",       int'(bus.Q_DO),       int'(exp_q[0]));
            check("last",    int'(bus.Last_SO),    (exp_q.size() == 1) ? 1 : 0);
         end
`ifdef FF_BANK_RD_FRAME_CNT_EN
         check("frame_cnt", int'(FrameCnt_DO), m_frames);
`endif
      end
      // Advance the model with the inputs the DUT will sample at the coming edge.
      if (!Rst_RBI) begin
         exp_q.delete();
         m_known  = 1'b1;
         m_frames = 0;
      end else if (m_known) begin
         if (exp_q.size() != 0) begin
            if (bus.Ready_SI) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) m_frames = (m_frames + 1) % 256;
            end
         end else if (bus.Load_SI) begin
            for (int k = 0; k < NE; k++) exp_q.push_back(bus.D_DI[k*DW +: DW]);
         end
      end
   end

   task automatic step(input bit rst_n, input bit load, input bit ready, input logic [NE*DW-1:0] d);
      Rst_RBI      = rst_n;
      bus.Load_SI  = load;
      bus.Ready_SI = ready;
      bus.D_DI     = d;
      @(posedge Clk_CI);
      #1;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         step(1'b1, 1'b0, 1'b1, '0);
      end
      check("drain_done", exp_q.size(), 0);
   endtask

   function automatic logic [NE*DW-1:0] mk_seq(input int base);
      logic [NE*DW-1:0] d;
      for (int k = 0; k < NE; k++) d[k*DW +: DW] = DW'(base + k);
      return d;
   endfunction

   function automatic logic [NE*DW-1:0] mk_alt();
      logic [NE*DW-1:0] d;
      for (int k = 0; k < NE; k++) d[k*DW +: DW] = (k % 2 == 0) ? DW'(-512) : DW'(511);
      return d;
   endfunction

   function automatic logic [NE*DW-1:0] mk_const(input int v);
      logic [NE*DW-1:0] d;
      for (int k = 0; k < NE; k++) d[k*DW +: DW] = DW'(v);
      return d;
   endfunction

   function automatic logic [NE*DW-1:0] mk_rand();
      logic [NE*DW-1:0] d;
      for (int k = 0; k < NE; k++) d[k*DW +: DW] = DW'($urandom);
      return d;
   endfunction

   initial begin
      // Reset
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b1, mk_seq(1));
      step(1'b1, 1'b0, 1'b0, '0);

      // Frame 1..8 with continuous ready
      step(1'b1, 1'b1, 1'b1, mk_seq(1));
      check("first_word_valid", int'(bus.Valid_SO), 1);
      check("first_word_q",     int'(bus.Q_DO),     1);
      for (int i = 0; i < NE + 2; i++) step(1'b1, 1'b0, 1'b1, '0);

      // Back-pressure on extreme signed values
      step(1'b1, 1'b1, 1'b1, mk_alt());
      for (int i = 0; i < 4 * NE; i++) begin
         bit rdy;
         rdy = (i % 4 == 0) || (i % 4 == 3);
         step(1'b1, 1'b0, rdy, '0);
      end
      drain(40);

      // Load pulsed mid-frame is ignored
      step(1'b1, 1'b1, 1'b0, mk_seq(20));
      step(1'b1, 1'b0, 1'b1, '0);
      step(1'b1, 1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 1'b0, mk_const(16'h155));
      step(1'b1, 1'b1, 1'b1, mk_const(16'h155));
      drain(40);

      // Reset after three transfers, then restart from entry 0
      step(1'b1, 1'b1, 1'b1, mk_seq(-3));
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, '0);
      step(1'b0, 1'b0, 1'b1, '0);
      check("rst_valid",   int'(bus.Valid_SO),   0);
      check("rst_q",       int'(bus.Q_DO),       0);
      check("rst_loadrdy", int'(bus.LoadRdy_SO), 1);
      step(1'b1, 1'b1, 1'b0, mk_seq(100));
      check("restart_q", int'(bus.Q_DO), 100);
      drain(40);

      // Load held high through the last transfer: one idle gap, then the next frame
      for (int i = 0; i < 2 * (NE + 1) + 1; i++) step(1'b1, 1'b1, 1'b1, mk_seq(-200));
      drain(40);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) < 7), mk_rand());
      end
      drain(60);

`ifdef FF_BANK_RD_FRAME_CNT_EN
      step(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 257 * (NE + 1); i++) step(1'b1, 1'b1, 1'b1, mk_rand());
      check("frame_cnt_257", int'(FrameCnt_DO), 1);
      step(1'b0, 1'b0, 1'b0, '0);
      check("frame_cnt_rst", int'(FrameCnt_DO), 0);
`endif

      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      @(negedge Clk_CI);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ff_bank_rd.md
FF_BANK_RD -- requirements
Module: ff_bank_rd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, bit width of one signed data word.
REQ-002 SHALL have parameter NUM_ENTRIES, default 8, words per frame (power of two, 2..64).
REQ-003 SHALL have port Clk_CI  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port Rst_RBI  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port Load_SI  input  1  parallel-load strobe, active high.
REQ-006 SHALL have port D_DI  input  NUM_ENTRIES*DATA_WIDTH  frame data; entry k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port LoadRdy_SO  output  1  high when a load is accepted this cycle.
REQ-008 SHALL have port Ready_SI  input  1  downstream ready.
REQ-009 SHALL have port Valid_SO  output  1  Q_DO holds a valid word.
REQ-010 SHALL have port Q_DO  output  DATA_WIDTH, signed  current word.
REQ-011 SHALL have port Last_SO  output  1  current word is entry NUM_ENTRIES-1.

Function
REQ-012 SHALL implement FSM states IDLE and STREAM, with LoadRdy_SO=1 only in IDLE.
REQ-013 In IDLE, Load_SI=1 SHALL capture all D_DI entries into the bank, set the read index to 0 and enter STREAM next cycle.
REQ-014 Load_SI in STREAM SHALL be ignored, with the bank and index unchanged.
REQ-015 Latency: load in cycle N SHALL give Valid_SO=1 with Q_DO=entry 0 in cycle N+1.
REQ-016 A transfer SHALL occur on a cycle with Valid_SO=1 and Ready_SI=1; the index then increments by 1.
REQ-017 While Valid_SO=1 and Ready_SI=0, Q_DO, Last_SO and the index SHALL hold stable.
REQ-018 Last_SO SHALL equal Valid_SO AND (index==NUM_ENTRIES-1).
REQ-019 A transfer with Last_SO=1 SHALL return the FSM to IDLE; no index wrap SHALL be visible.
REQ-020 In IDLE, Q_DO SHALL be 0 and Valid_SO and Last_SO SHALL be 0.
REQ-021 The bank SHALL retain data after a frame completes, until the next load.
REQ-022 A load SHALL NOT be accepted in the same cycle as the last transfer; the earliest load is the following (IDLE) cycle.

Reset
REQ-023 Rst_RBI=0 at a rising edge SHALL force: FSM=IDLE, index=0, bank all zero, Valid_SO=0, Last_SO=0, Q_DO=0, LoadRdy_SO=1.
REQ-024 Reset SHALL take priority over Load_SI and over transfers, including mid-frame, and SHALL discard the frame.
REQ-025 No asynchronous reset path SHALL exist.

Configuration
REQ-026 Macro FF_BANK_RD_FRAME_CNT_EN defined SHALL add port FrameCnt_DO  output  8, which increments on each last transfer, wraps 255->0, and resets to 0.
REQ-027 Without FF_BANK_RD_FRAME_CNT_EN, the port and counter SHALL be absent, with all other behaviour identical.

Structure
REQ-028 Package ff_bank_rd_pkg SHALL hold the FSM state enum, the default DATA_WIDTH/NUM_ENTRIES constants, and the index width function (clog2).
REQ-029 Sub-module ff_bank_rd_store SHALL implement the load-enabled register bank with synchronous clear; the top holds the FSM, index and output mux.

Verification
REQ-030 Reset then load entries 0..7 = 1..8 with Ready_SI=1 -> Valid_SO from the next cycle, Q_DO 1..8 on consecutive cycles, Last_SO only with 8, then IDLE.
REQ-031 Ready_SI toggled 1,0,0,1 during a frame of entries -512 and 511 -> Q_DO held while Ready_SI=0, no word lost or duplicated, signed values intact.
REQ-032 Load_SI pulsed in STREAM with new data all 0x155 -> ignored; the original frame completes unchanged.
REQ-033 Rst_RBI=0 for one cycle after 3 transfers -> next cycle Valid_SO=0, Q_DO=0, LoadRdy_SO=1; a new load restarts at entry 0.
REQ-034 Load_SI held high through the last transfer -> no load that cycle; the load is accepted in the next cycle, with Valid_SO gap exactly 1 cycle.
REQ-035 With FF_BANK_RD_FRAME_CNT_EN, 257 complete frames -> FrameCnt_DO=1; after reset -> 0.
